// File: rtl/serial_mag_comp_if.sv
// Handshake and operand/result bundle for the bit-serial magnitude comparator.
interface serial_mag_comp_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             lt;
  logic             eq;
  logic             gt;

  modport master (
    output start, signed_en, a, b,
    input  busy, done, lt, eq, gt
  );

  modport slave (
    input  start, signed_en, a, b,
    output busy, done, lt, eq, gt
  );
endinterface

// File: rtl/serial_mag_comp.sv
// Bit-serial MSB-first magnitude comparator with early termination and
// optional two's-complement mode; one 1-bit compare slice reused per clock.
module serial_mag_comp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_mag_comp_if.slave bus
);
  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] MSB_IDX = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  a_r, a_n;
  logic [WIDTH-1:0]  b_r, b_n;
  logic              signed_r, signed_n;
  logic [IDXW-1:0]   idx, idx_n;
  logic              lt_r, lt_n;
  logic              eq_r, eq_n;
  logic              gt_r, gt_n;
  logic              bit_a, bit_b;

  assign bit_a = a_r[idx];
  assign bit_b = b_r[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      signed_r <= 1'b0;
      idx      <= '0;
      lt_r     <= 1'b0;
      eq_r     <= 1'b0;
      gt_r     <= 1'b0;
    end else begin
      state    <= state_n;
      a_r      <= a_n;
      b_r      <= b_n;
      signed_r <= signed_n;
      idx      <= idx_n;
      lt_r     <= lt_n;
      eq_r     <= eq_n;
      gt_r     <= gt_n;
    end
  end

  always_comb begin
    state_n  = state;
    a_n      = a_r;
    b_n      = b_r;
    signed_n = signed_r;
    idx_n    = idx;
    lt_n     = lt_r;
    eq_n     = eq_r;
    gt_n     = gt_r;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          a_n      = bus.a;
          b_n      = bus.b;
          signed_n = bus.signed_en;
          idx_n    = MSB_IDX;
          lt_n     = 1'b0;
          eq_n     = 1'b0;
          gt_n     = 1'b0;
          state_n  = SCAN;
        end
      end
      SCAN: begin
        if (bit_a != bit_b) begin
          // A set sign bit marks the smaller value in two's complement.
          if (signed_r && (idx == MSB_IDX)) begin
            gt_n = bit_b;
            lt_n = bit_a;
          end else begin
            gt_n = bit_a;
            lt_n = bit_b;
          end
          eq_n    = 1'b0;
          state_n = DONE;
        end else if (idx == '0) begin
          eq_n    = 1'b1;
          state_n = DONE;
        end else begin
          idx_n = idx - IDXW'(1);
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.lt   = lt_r;
  assign bus.eq   = eq_r;
  assign bus.gt   = gt_r;
endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed self-checking bench for serial_mag_comp at WIDTH = 8, 16 and 2.
module tb_serial_mag_comp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  serial_mag_comp_if #(.WIDTH(8))  b8 ();
  serial_mag_comp_if #(.WIDTH(16)) b16 ();
  serial_mag_comp_if #(.WIDTH(2))  b2 ();

  serial_mag_comp #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8.slave));
  serial_mag_comp #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));
  serial_mag_comp #(.WIDTH(2))  dut2  (.clk(clk), .rst(rst), .bus(b2.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] res8();
    return {b8.lt, b8.eq, b8.gt};
  endfunction

  // One full transaction on the 8-bit DUT; res is {lt,eq,gt}.
  task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic sv, input int lat, input logic [2:0] res);
    int n;
    b8.a = av; b8.b = bv; b8.signed_en = sv; b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    n = 1;
    check({tag, ":busy1"}, 32'(b8.busy), 32'd1);
    check({tag, ":clr"}, 32'(res8()), 32'd0);
    while (!b8.done && n < 40) begin
      tick();
      n++;
    end
    check({tag, ":lat"}, 32'(n), 32'(lat));
    check({tag, ":res"}, 32'(res8()), 32'(res));
    tick();
    check({tag, ":idle"}, 32'({b8.busy, b8.done}), 32'd0);
    check({tag, ":hold"}, 32'(res8()), 32'(res));
  endtask

  initial begin
    int n;
    b8.start = 0;  b8.signed_en = 0;  b8.a = '0;  b8.b = '0;
    b16.start = 0; b16.signed_en = 0; b16.a = '0; b16.b = '0;
    b2.start = 0;  b2.signed_en = 0;  b2.a = '0;  b2.b = '0;
    rst = 1'b1;
    tick(); tick();
    check("rst_state", 32'({b8.busy, b8.done, b8.lt, b8.eq, b8.gt}), 32'd0);
    rst = 1'b0;
    tick();

    run8("a5_25",   8'hA5, 8'h25, 1'b0, 2, 3'b001);
    run8("3c_3c",   8'h3C, 8'h3C, 1'b0, 9, 3'b010);
    run8("40_41",   8'h40, 8'h41, 1'b0, 9, 3'b100);
    run8("80_01s",  8'h80, 8'h01, 1'b1, 2, 3'b100);
    run8("80_01u",  8'h80, 8'h01, 1'b0, 2, 3'b001);
    run8("fe_ffs",  8'hFE, 8'hFF, 1'b1, 9, 3'b100);
    run8("7f_80s",  8'h7F, 8'h80, 1'b1, 2, 3'b001);

    // start held high; mid-scan operand change ignored; re-accept at T+10
    b8.a = 8'h10; b8.b = 8'h11; b8.signed_en = 1'b0; b8.start = 1'b1;
    tick();                          // cycle T+1
    tick(); tick();                  // cycle T+3
    b8.a = 8'hFF; b8.b = 8'h00;
    for (int k = 4; k <= 8; k++) begin
      tick();
      check("hold_nodone", 32'(b8.done), 32'd0);
    end
    tick();                          // cycle T+9
    check("hold_done", 32'(b8.done), 32'd1);
    check("hold_res", 32'(res8()), 32'b100);
    tick();                          // cycle T+10, IDLE
    check("hold_idle", 32'(b8.busy), 32'd0);
    tick();                          // accepted at edge T+10
    check("reaccept_busy", 32'(b8.busy), 32'd1);
    b8.start = 1'b0;
    tick();
    check("reaccept_done", 32'(b8.done), 32'd1);
    check("reaccept_res", 32'(res8()), 32'b001);
    tick();

    // reset mid-scan abandons the comparison
    b8.a = 8'h00; b8.b = 8'h01; b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    tick(); tick(); tick();          // cycle T+4
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst", 32'({b8.busy, b8.done, b8.lt, b8.eq, b8.gt}), 32'd0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      if (b8.done) n++;
      tick();
    end
    check("midrst_nodone", 32'(n), 32'd0);
    run8("07_07", 8'h07, 8'h07, 1'b0, 9, 3'b010);

    // WIDTH=16: MSB differs, unsigned
    b16.a = 16'h8000; b16.b = 16'h7FFF; b16.signed_en = 1'b0; b16.start = 1'b1;
    tick();
    b16.start = 1'b0;
    tick();
    check("w16_done", 32'(b16.done), 32'd1);
    check("w16_res", 32'({b16.lt, b16.eq, b16.gt}), 32'b001);

    // WIDTH=2: equal operands finish at T+3
    b2.a = 2'b01; b2.b = 2'b01; b2.signed_en = 1'b0; b2.start = 1'b1;
    tick();
    b2.start = 1'b0;
    tick();
    check("w2_early", 32'(b2.done), 32'd0);
    tick();
    check("w2_done", 32'(b2.done), 32'd1);
    check("w2_res", 32'({b2.lt, b2.eq, b2.gt}), 32'b010);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_mag_comp.md
Name: serial_mag_comp

Overview:
- Parametrised, bit-serial magnitude comparator; successor to the fixed 4-bit combinational comparator.
- Latches two WIDTH-bit operands on a start handshake and resolves lt/eq/gt MSB-first, one bit per clock, reusing a single 1-bit compare slice.
- Terminates early at the first differing bit.
- Supports a runtime unsigned/two's-complement mode.
- Used where wide operands make a flat comparator tree too costly in area.

Parameters:
- WIDTH, 8, operand width in bits; legal range is WIDTH >= 2.
- IDXW, $clog2(WIDTH), width of the internal bit-index counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; accepted only in IDLE.
- signed_en  input  1  sampled with start; 1 = two's-complement compare, 0 = unsigned.
- a  input  WIDTH  operand A; sampled on accepted start.
- b  input  WIDTH  operand B; sampled on accepted start.
- busy  output  1  high in SCAN and DONE.
- done  output  1  one-cycle pulse; result valid from this cycle.
- lt  output  1  A < B.
- eq  output  1  A == B.
- gt  output  1  A > B.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset (any state, including mid-SCAN):
  - state = IDLE; busy, done, lt, eq, gt = 0.
  - Operand registers and index counter are cleared.
  - An in-flight comparison is abandoned with no done pulse.
- IDLE state:
  - busy = 0.
  - If start = 1 at an edge: latch a, b and signed_en; set idx = WIDTH-1; clear lt, eq, gt to 0; go to SCAN.
  - Otherwise stay in IDLE and hold the last result.
- SCAN state (busy = 1): each cycle compares bit a_r[idx] against b_r[idx].
  - Bits differ, unsigned compare, or idx < WIDTH-1: gt = a_r[idx], lt = b_r[idx], eq = 0; go to DONE.
  - Bits differ at idx = WIDTH-1 with signed_en_r = 1: the sense is inverted, so gt = b_r[idx] and lt = a_r[idx]. A set sign bit means the smaller value.
  - Bits equal and idx = 0: eq = 1; go to DONE.
  - Bits equal and idx > 0: idx decrements; stay in SCAN.
- DONE state:
  - busy = 1 and done = 1 for exactly one cycle; the next state is IDLE.
  - lt, eq and gt were registered on the same edge that entered DONE.
  - They hold until the next accepted start or reset.
- Latency, with start accepted at edge T:
  - First difference at bit i: done is high during cycle T+WIDTH-i+1.
  - Equal operands: done is high during cycle T+WIDTH+1.
  - Minimum latency is T+2 (MSB differs).
- Output invariant: exactly one of lt, eq, gt is 1 whenever done = 1. The outputs are all 0 between an accepted start and its done.
- start while busy (SCAN or DONE): ignored; no queuing.
  - Operands and signed_en changing during SCAN have no effect.
- Back-to-back operation: a start held high continuously is re-accepted in the IDLE cycle following DONE.
  - Minimum issue interval is therefore latency + 1 cycles.
- Signed equality: sign bits equal → the remaining bits are compared as unsigned. This is correct for two's complement.
- WIDTH parametrisation: the index counter must not wrap; the terminal test is idx == 0, never an underflow.
- Outputs are registered; no combinational path exists from a or b to lt, eq or gt.

Test Plan:
- WIDTH=8, signed_en=0, a=8'hA5, b=8'h25, start at T → done during T+2; gt=1, lt=0, eq=0; busy high during T+1..T+2.
- a=8'h3C, b=8'h3C, signed_en=0 → done during T+9, eq=1. a=8'h40, b=8'h41 → done during T+9, lt=1.
- a=8'h80, b=8'h01: with signed_en=1 → done during T+2, lt=1. With signed_en=0 → gt=1. Also a=8'hFE(-2), b=8'hFF(-1), signed_en=1 → done during T+9, lt=1.
- Start a=8'h10, b=8'h11. During T+3 pulse start with a=8'hFF, b=8'h00 and change the a/b pins → ignored; original result lt=1 at T+9. start held high continuously → second compare accepted at T+10.
- Start a=8'h00, b=8'h01; assert rst during T+4 → next cycle busy=0, done=0, lt/eq/gt=0; no done pulse. A following start a=8'h07, b=8'h07 completes normally with eq=1.
- WIDTH=2 and WIDTH=16 builds: a=16'h8000, b=16'h7FFF, signed_en=0 → gt=1 during T+2. WIDTH=2, a=2'b01, b=2'b01 → eq=1 during T+3.
